// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multicycle ARM core: walks the shared ALU, memory port and IR
// through fetch/decode/memory/execute steps and emits raw per-cycle datapath controls.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       ir_w,
    output logic       next_pc,
    output logic       branch,
    output logic       reg_w,
    output logic       mem_w,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       alu_op,
    output logic [1:0] result_src,
    output logic       undef,
    output logic       mem_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(MEM_TIMEOUT);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_wait_cnt;
    logic            w_in_mem;
    logic            w_next_mem;
    logic            w_timeout;

    assign w_in_mem   = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
    assign w_next_mem = (w_next == S_FETCH) || (w_next == S_MEMREAD) || (w_next == S_MEMWRITE);
    assign w_timeout  = (MEM_TIMEOUT > 0) && w_in_mem && !mem_ready && (r_wait_cnt == TO_VAL);
    assign state      = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // A timeout re-enters FETCH from FETCH, which still counts as a fresh entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (w_next_mem && ((w_next != r_state) || w_timeout)) begin
            r_wait_cnt <= '0;
        end else if (w_in_mem && !mem_ready && (r_wait_cnt != '1)) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b00:   w_next = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_MEMWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            default:    w_next = S_FETCH;
        endcase
        if (w_timeout) w_next = S_FETCH;
    end

    always_comb begin
        mem_req    = 1'b0;
        ir_w       = 1'b0;
        next_pc    = 1'b0;
        branch     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 1'b0;
        result_src = 2'b00;
        undef      = 1'b0;
        mem_err    = w_timeout;
        case (r_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                ir_w       = mem_ready;
                next_pc    = mem_ready;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                undef      = (op == 2'b11);
            end
            S_MEMADR:   alu_src_b = 2'b01;
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            S_EXECUTER: alu_op = 1'b1;
            S_EXECUTEI: begin
                alu_src_b = 2'b01;
                alu_op    = 1'b1;
            end
            S_ALUWB:    reg_w = 1'b1;
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
            end
            default: ;
        endcase
        // Async reset forces FETCH, whose ir_w/next_pc would otherwise follow mem_ready.
        if (reset) begin
            ir_w    = 1'b0;
            next_pc = 1'b0;
            branch  = 1'b0;
            reg_w   = 1'b0;
            mem_w   = 1'b0;
            undef   = 1'b0;
            mem_err = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm, built with a 3-cycle memory timeout.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       mem_req, ir_w, next_pc, branch, reg_w, mem_w, adr_src, alu_op, undef, mem_err;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_control_fsm #(.MEM_TIMEOUT(3)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .ir_w(ir_w), .next_pc(next_pc), .branch(branch),
        .reg_w(reg_w), .mem_w(mem_w), .adr_src(adr_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
        .undef(undef), .mem_err(mem_err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset = 1'b1; op = 2'b00; funct = 6'b0; mem_ready = 1'b1;
        settle();
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_ir_w", 8'(ir_w), 8'd0);
        chk("rst_next_pc", 8'(next_pc), 8'd0);
        cyc();
        reset = 1'b0;
        settle();
        chk("rel_ir_w", 8'(ir_w), 8'd1);
        chk("rel_next_pc", 8'(next_pc), 8'd1);

        // STR path, interrupted by reset while waiting in MEMWRITE
        op = 2'b01; funct = 6'b011000;
        cyc(); settle(); chk("str1_state", 8'(state), 8'd1);
        cyc(); settle(); chk("str1_madr", 8'(state), 8'd2);
        mem_ready = 1'b0;
        cyc(); settle(); chk("str1_mwr", 8'(state), 8'd5);
        chk("str1_mem_w", 8'(mem_w), 8'd1);
        reset = 1'b1;
        settle();
        chk("rst_mid_state", 8'(state), 8'd0);
        chk("rst_mid_mem_w", 8'(mem_w), 8'd0);
        cyc();
        reset = 1'b0; mem_ready = 1'b1;

        // ADD register
        op = 2'b00; funct = 6'b001000;
        settle();
        chk("add_s0", 8'(state), 8'd0);
        chk("add_fetch_sel", {alu_src_a, alu_src_b, result_src, mem_req, adr_src}, 8'b01_10_10_1_0);
        cyc(); settle(); chk("add_s1", 8'(state), 8'd1);
        chk("add_dec_sel", {alu_src_a, alu_src_b, result_src, reg_w, ir_w}, 8'b01_10_10_0_0);
        cyc(); settle(); chk("add_s6", 8'(state), 8'd6);
        chk("add_exe", {alu_op, alu_src_b, reg_w}, 8'b1_00_0);
        cyc(); settle(); chk("add_s8", 8'(state), 8'd8);
        chk("add_wb", {reg_w, result_src, alu_op}, 8'b1_00_0);
        cyc(); settle(); chk("add_end", 8'(state), 8'd0);

        // LDR with two wait cycles in MEMREAD
        op = 2'b01; funct = 6'b011001;
        cyc(); settle(); chk("ldr_s1", 8'(state), 8'd1);
        cyc(); settle(); chk("ldr_s2", 8'(state), 8'd2);
        chk("ldr_adr", {alu_src_a, alu_src_b, mem_req}, 8'b00_01_0);
        mem_ready = 1'b0;
        cyc(); settle(); chk("ldr_s3a", 8'(state), 8'd3);
        chk("ldr_rd", {mem_req, adr_src, result_src, mem_w}, 8'b1_1_00_0);
        cyc(); settle(); chk("ldr_s3b", 8'(state), 8'd3);
        cyc();
        mem_ready = 1'b1;
        settle(); chk("ldr_s3c", 8'(state), 8'd3);
        chk("ldr_no_err", 8'(mem_err), 8'd0);
        cyc(); settle(); chk("ldr_s4", 8'(state), 8'd4);
        chk("ldr_wb", {result_src, reg_w}, 8'b01_1);
        cyc(); settle(); chk("ldr_end", 8'(state), 8'd0);

        // STR, zero wait, then branch
        op = 2'b01; funct = 6'b011000;
        chk("str_fetch_mem_w", 8'(mem_w), 8'd0);
        cyc(); cyc(); settle(); chk("str_s2", 8'(state), 8'd2);
        chk("str_madr_mem_w", 8'(mem_w), 8'd0);
        cyc(); settle(); chk("str_s5", 8'(state), 8'd5);
        chk("str_wr", {mem_w, adr_src, mem_req, reg_w}, 8'b1_1_1_0);
        cyc(); settle(); chk("str_end", 8'(state), 8'd0);
        op = 2'b10; funct = 6'b000000;
        cyc(); settle(); chk("br_s1", 8'(state), 8'd1);
        cyc(); settle(); chk("br_s9", 8'(state), 8'd9);
        chk("br_sel", {branch, alu_src_a, alu_src_b, result_src, reg_w}, 8'b1_10_01_10_0);
        cyc(); settle(); chk("br_end", 8'(state), 8'd0);

        // Undefined op
        op = 2'b11;
        cyc(); settle(); chk("und_s1", 8'(state), 8'd1);
        chk("und_pulse", {undef, reg_w, mem_w}, 8'b1_0_0);
        cyc(); settle(); chk("und_end", 8'(state), 8'd0);
        chk("und_clear", 8'(undef), 8'd0);

        // Fetch timeout: mem_err on the 4th waiting cycle
        op = 2'b00; funct = 6'b001000; mem_ready = 1'b0;
        settle(); chk("to_c1", {mem_err, ir_w}, 8'b0_0);
        cyc(); settle(); chk("to_c2", {mem_err, ir_w}, 8'b0_0);
        cyc(); settle(); chk("to_c3", {mem_err, ir_w}, 8'b0_0);
        cyc(); settle(); chk("to_c4", {mem_err, ir_w, next_pc}, 8'b1_0_0);
        chk("to_c4_state", 8'(state), 8'd0);
        cyc(); settle(); chk("to_reentry", {mem_err, state}, 8'b0_0000);
        cyc(); settle(); chk("to_r2", 8'(mem_err), 8'd0);
        cyc(); settle(); chk("to_r3", 8'(mem_err), 8'd0);
        cyc();
        mem_ready = 1'b1;
        settle(); chk("to_ready_wins", {mem_err, ir_w, next_pc}, 8'b0_1_1);
        cyc(); settle(); chk("to_decode", 8'(state), 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
